ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Parametrised multi-cycle step sequencer for the MiniSRC control path. It generalises the fixed 5-step ring to variable-length instructions of 2..MAX_STEPS steps. It adds a fetch/memory handshake with ack and timeout, plus HALT and ERR states. It owns the IR and the memory-data capture register; the external decoder reads oIR and returns per-instruction length and memory-step information.

Parameters:
DATA_W, 32, instruction/memory data width
MAX_STEPS, 8, maximum steps per instruction including fetch; width of oStep (≥2)
STEP_W, $clog2(MAX_STEPS), step index width (derived, localparam)
MEM_TIMEOUT, 15, cycles without iMemAck in FETCH/MEM before ERR (≥1)

Ports:
iClk  in  1  clock, rising edge
nRst  in  1  reset, asynchronous, active-low
iRdy  in  1  global advance enable for EXEC steps
iMemData  in  DATA_W  memory read data
iMemAck  in  1  memory completes current request this cycle
iLen  in  STEP_W+1  total steps of current instruction (from decoder on oIR)
iMemEn  in  1  current instruction has a memory step
iMemStep  in  STEP_W  step index of memory access (1..MAX_STEPS-1)
iMemWr  in  1  memory step is a write (else read)
iHalt  in  1  current instruction is HLT
iRun  in  1  resume pulse from HALT
oMemRead  out  1  memory read request
oMemWrite  out  1  memory write request
oIR  out  DATA_W  instruction register
oMDR  out  DATA_W  captured memory read data
oStep  out  MAX_STEPS  one-hot current step; all-zero in IDLE/HALT/ERR
oFetch  out  1  in FETCH
oHalted  out  1  in HALT
oErr  out  1  sticky timeout error

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALT, ERR. Register stp[STEP_W-1:0] and timeout counter tmo.
- Reset (async, any state, mid-access included): state=IDLE, stp=0, tmo=0, oIR=0, oMDR=0.
- All outputs are 0 in reset/IDLE; requests drop immediately on reset assertion.
- oStep = one-hot(stp) in FETCH/EXEC/MEM.
- oMemRead = FETCH | (MEM & ~iMemWr).
- oMemWrite = MEM & iMemWr.
- Requests are combinational from registered state.
- IDLE -> FETCH on first edge with iRdy=1.
- FETCH (stp=0): request held until ack; iRdy is ignored. On edge with iMemAck: oIR<=iMemData, stp<=1, state EXEC.
- Effective length L = clamp(iLen, 2, MAX_STEPS).
- EXEC: holds while iRdy=0. On edge with iRdy=1:
  - iHalt & stp==1 -> HALT.
  - else n=stp+1; if n≥L -> FETCH, stp=0.
  - else if iMemEn & n==iMemStep -> MEM, stp=n.
  - else stp=n.
- iMemStep==0 or ≥L: memory step is ignored.
- MEM: request held until ack. On ack edge: if read, oMDR<=iMemData. Then n=stp+1; n≥L -> FETCH, stp=0; else EXEC, stp=n.
- Timeout: tmo clears on entering FETCH/MEM and on every ack. It increments each FETCH/MEM cycle without ack. When tmo==MEM_TIMEOUT-1 and no ack at the edge -> ERR. An ack on that same edge wins.
- HALT: no requests; oHalted=1. iRun edge -> FETCH, stp=0. iRun outside HALT is ignored.
- ERR: oErr=1, no requests; exit only by reset.
- Decoder inputs are sampled only at the advancing edge; changes between edges have no effect.

Optional Feature:
CTRL_SEQ_SSTEP_EN: adds ports iStepMode (in, 1) and iStepGo (in, 1).
- When iStepMode=1, a FETCH entry from EXEC, MEM or IDLE waits in IDLE until an iStepGo edge, giving one instruction per pulse.
- iStepGo while not waiting is ignored.
- Without the macro: ports absent; behaviour as above.

Test Plan:
- Reset, iRdy=1, ack one cycle after every request, iLen=4, iMemEn=0 -> oStep sequence 01,02,04,08,01. oIR=0x1234_5678 from fetch data.
- Load: iLen=5, iMemEn=1, iMemStep=3, iMemWr=0, ack delayed 3 cycles -> oMemRead high 4 cycles with oStep=0x08. oMDR=0xDEAD_BEEF after ack, then step 0x10, then FETCH.
- iRdy=0 for 3 cycles in EXEC at stp=2 -> oStep stays 0x04, no requests. iLen=1 clamps to 2; iLen=12 clamps to 8.
- iHalt=1 at stp=1 -> oHalted=1, oStep=0, no requests for 10 cycles. iRun pulse -> oFetch next cycle.
- No ack in FETCH, MEM_TIMEOUT=15 -> oErr=1 after exactly 15 request cycles, sticky. Ack on the 15th cycle -> no error.
- nRst asserted mid-MEM write -> oMemWrite=0 immediately, state IDLE, oIR=0. Under CTRL_SEQ_SSTEP_EN with iStepMode=1 -> one instruction per iStepGo pulse.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: variable-length multi-cycle step sequencer for the MiniSRC control path.
// Fetches an instruction into IR, then walks the decoder-reported number of steps. An
// optional memory step is inserted, and both fetch and memory accesses use an ack
// handshake guarded by a timeout.
// States: IDLE, FETCH, EXEC, MEM, HALT, ERR.
// Optional macro CTRL_SEQ_SSTEP_EN adds iStepMode/iStepGo single-instruction stepping.
// With step mode on, every fetch first parks in IDLE until an iStepGo pulse arrives.
module ctrl_sequencer #(
   parameter int unsigned  DATA_W      = 32,
   parameter int unsigned  MAX_STEPS   = 8,
   parameter int unsigned  MEM_TIMEOUT = 15,
   localparam int unsigned STEP_W      = $clog2(MAX_STEPS)
) (
   input  logic                 iClk,
   input  logic                 nRst,
   input  logic                 iRdy,
   input  logic [DATA_W-1:0]    iMemData,
   input  logic                 iMemAck,
   input  logic [STEP_W:0]      iLen,
   input  logic                 iMemEn,
   input  logic [STEP_W-1:0]    iMemStep,
   input  logic                 iMemWr,
   input  logic                 iHalt,
   input  logic                 iRun,
`ifdef CTRL_SEQ_SSTEP_EN
   input  logic                 iStepMode,
   input  logic                 iStepGo,
`endif
   output logic                 oMemRead,
   output logic                 oMemWrite,
   output logic [DATA_W-1:0]    oIR,
   output logic [DATA_W-1:0]    oMDR,
   output logic [MAX_STEPS-1:0] oStep,
   output logic                 oFetch,
   output logic                 oHalted,
   output logic                 oErr
);

   // Timeout counter only needs to reach MEM_TIMEOUT-1.
   localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [STEP_W:0]  MIN_LEN  = (STEP_W + 1)'(2);
   localparam logic [STEP_W:0]  MAX_LEN  = (STEP_W + 1)'(MAX_STEPS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StMem,
      StHalt,
      StErr
   } state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   stp_q, stp_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;

   logic [STEP_W:0]     eff_len;
   logic [STEP_W:0]     step_nxt;
   logic                last_step;
   logic                mem_hit;
   logic                tmo_last;
   logic                idle_go;
   state_e              fetch_target;
   logic [MAX_STEPS-1:0] step_oh;

`ifdef CTRL_SEQ_SSTEP_EN
   // In step mode each new instruction parks in IDLE until released by iStepGo.
   assign idle_go      = iStepMode ? iStepGo : iRdy;
   assign fetch_target = iStepMode ? StIdle : StFetch;
`else
   assign idle_go      = iRdy;
   assign fetch_target = StFetch;
`endif

   // Clamp the decoder-reported length into the legal 2..MAX_STEPS range.
   always_comb begin
      if (iLen < MIN_LEN) begin
         eff_len = MIN_LEN;
      end else if (iLen > MAX_LEN) begin
         eff_len = MAX_LEN;
      end else begin
         eff_len = iLen;
      end
   end

   // Step bookkeeping shared by EXEC and MEM; one extra bit so n==MAX_STEPS is representable.
   assign step_nxt  = {1'b0, stp_q} + (STEP_W + 1)'(1);
   assign last_step = (step_nxt >= eff_len);
   // A memory step of 0 or >= L never matches because last_step is tested first.
   assign mem_hit   = iMemEn && (iMemStep != '0) && ({1'b0, iMemStep} == step_nxt);
   assign tmo_last  = (tmo_q == TMO_LAST);
   assign step_oh   = MAX_STEPS'(1) << stp_q;

   // State, step, timeout and capture registers with asynchronous active-low reset.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q <= StIdle;
         stp_q   <= '0;
         tmo_q   <= '0;
         ir_q    <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         stp_q   <= stp_d;
         tmo_q   <= tmo_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
      end
   end

   // Next-state logic: step advance, memory handshake, timeout and halt handling.
   always_comb begin
      state_d = state_q;
      stp_d   = stp_q;
      tmo_d   = tmo_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;

      unique case (state_q)
         StIdle: begin
            if (idle_go) begin
               state_d = StFetch;
               stp_d   = '0;
            end
         end

         StFetch: begin
            // iRdy is deliberately ignored while the fetch is outstanding.
            if (iMemAck) begin
               ir_d    = iMemData;
               stp_d   = STEP_W'(1);
               state_d = StExec;
               tmo_d   = '0;
            end else if (tmo_last) begin
               state_d = StErr;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         StExec: begin
            if (iRdy) begin
               if (iHalt && (stp_q == STEP_W'(1))) begin
                  state_d = StHalt;
               end else if (last_step) begin
                  state_d = fetch_target;
                  stp_d   = '0;
               end else if (mem_hit) begin
                  state_d = StMem;
                  stp_d   = step_nxt[STEP_W-1:0];
               end else begin
                  stp_d = step_nxt[STEP_W-1:0];
               end
            end
         end

         StMem: begin
            if (iMemAck) begin
               tmo_d = '0;
               if (!iMemWr) begin
                  mdr_d = iMemData;
               end
               if (last_step) begin
                  state_d = fetch_target;
                  stp_d   = '0;
               end else begin
                  state_d = StExec;
                  stp_d   = step_nxt[STEP_W-1:0];
               end
            end else if (tmo_last) begin
               state_d = StErr;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         StHalt: begin
            if (iRun) begin
               state_d = StFetch;
               stp_d   = '0;
            end
         end

         StErr: begin
            // Sticky until reset.
         end

         default: begin
            state_d = StIdle;
            stp_d   = '0;
         end
      endcase

      // Every new FETCH/MEM visit starts with a fresh timeout window.
      if (state_d != state_q) begin
         tmo_d = '0;
      end
   end

   // Outputs decoded from registered state; requests fall as soon as reset forces IDLE.
   always_comb begin
      oMemRead  = 1'b0;
      oMemWrite = 1'b0;
      oStep     = '0;
      oFetch    = 1'b0;
      oHalted   = 1'b0;
      oErr      = 1'b0;
      unique case (state_q)
         StFetch: begin
            oMemRead = 1'b1;
            oFetch   = 1'b1;
            oStep    = step_oh;
         end
         StExec: begin
            oStep = step_oh;
         end
         StMem: begin
            oMemRead  = ~iMemWr;
            oMemWrite = iMemWr;
            oStep     = step_oh;
         end
         StHalt: begin
            oHalted = 1'b1;
         end
         StErr: begin
            oErr = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign oIR  = ir_q;
   assign oMDR = mdr_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer with default parameters (32/8/15).
// With CTRL_SEQ_SSTEP_EN defined, the single-step ports are driven and exercised too.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

   logic        iClk = 1'b0;
   logic        nRst;
   logic        iRdy;
   logic [31:0] iMemData;
   logic        iMemAck;
   logic [3:0]  iLen;
   logic        iMemEn;
   logic [2:0]  iMemStep;
   logic        iMemWr;
   logic        iHalt;
   logic        iRun;
`ifdef CTRL_SEQ_SSTEP_EN
   logic        iStepMode;
   logic        iStepGo;
`endif
   logic        oMemRead;
   logic        oMemWrite;
   logic [31:0] oIR;
   logic [31:0] oMDR;
   logic [7:0]  oStep;
   logic        oFetch;
   logic        oHalted;
   logic        oErr;

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   ctrl_sequencer dut (
      .iClk      (iClk),
      .nRst      (nRst),
      .iRdy      (iRdy),
      .iMemData  (iMemData),
      .iMemAck   (iMemAck),
      .iLen      (iLen),
      .iMemEn    (iMemEn),
      .iMemStep  (iMemStep),
      .iMemWr    (iMemWr),
      .iHalt     (iHalt),
      .iRun      (iRun),
`ifdef CTRL_SEQ_SSTEP_EN
      .iStepMode (iStepMode),
      .iStepGo   (iStepGo),
`endif
      .oMemRead  (oMemRead),
      .oMemWrite (oMemWrite),
      .oIR       (oIR),
      .oMDR      (oMDR),
      .oStep     (oStep),
      .oFetch    (oFetch),
      .oHalted   (oHalted),
      .oErr      (oErr)
   );

   // Advance one clock; sampling and driving happen 1ns after the rising edge.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic set_defaults();
      iRdy     = 1'b0;
      iMemData = 32'h0;
      iMemAck  = 1'b0;
      iLen     = 4'd4;
      iMemEn   = 1'b0;
      iMemStep = 3'd0;
      iMemWr   = 1'b0;
      iHalt    = 1'b0;
      iRun     = 1'b0;
`ifdef CTRL_SEQ_SSTEP_EN
      iStepMode = 1'b0;
      iStepGo   = 1'b0;
`endif
   endtask

   // Pulse reset between clock edges.
   task automatic do_reset();
      nRst = 1'b0;
      #3;
      nRst = 1'b1;
   endtask

   task automatic test_reset();
      set_defaults();
      iRdy = 1'b1;
      nRst = 1'b0;
      #2;
      checks++;
      if ({oMemRead, oMemWrite, oStep, oFetch, oHalted, oErr} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h",
                  {oMemRead, oMemWrite, oStep, oFetch, oHalted, oErr}, 13'h0);
      end
      checks++;
      if ({oIR, oMDR} !== 64'h0) begin
         errors++;
         $display("FAIL reset_regs got %h want %h", {oIR, oMDR}, 64'h0);
      end
      nRst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] exp_step [0:3];
      exp_step[0] = 8'h02;
      exp_step[1] = 8'h04;
      exp_step[2] = 8'h08;
      exp_step[3] = 8'h01;
      set_defaults();
      do_reset();
      iRdy = 1'b1;
      tick();
      checks++;
      if ({oFetch, oMemRead, oStep} !== {1'b1, 1'b1, 8'h01}) begin
         errors++;
         $display("FAIL basic_fetch got %h want %h", {oFetch, oMemRead, oStep}, 10'h301);
      end
      iMemAck  = 1'b1;
      iMemData = 32'h1234_5678;
      tick();
      iMemAck  = 1'b0;
      iMemData = 32'h0;
      checks++;
      if (oIR !== 32'h1234_5678) begin
         errors++;
         $display("FAIL basic_ir got %h want %h", oIR, 32'h1234_5678);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (oStep !== exp_step[i]) begin
            errors++;
            $display("FAIL basic_step%0d got %h want %h", i, oStep, exp_step[i]);
         end
         if (i < 3) tick();
      end
      checks++;
      if (oFetch !== 1'b1) begin
         errors++;
         $display("FAIL basic_refetch got %b want 1", oFetch);
      end
   endtask

   task automatic test_mem_read();
      set_defaults();
      do_reset();
      iRdy     = 1'b1;
      iLen     = 4'd5;
      iMemEn   = 1'b1;
      iMemStep = 3'd3;
      tick();
      iMemAck  = 1'b1;
      iMemData = 32'hA000_0001;
      tick();
      iMemAck  = 1'b0;
      iMemData = 32'h0;
      tick();
      tick();
      // Now in MEM at step 3; ack arrives on the fourth request cycle.
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({oMemRead, oMemWrite, oStep} !== {1'b1, 1'b0, 8'h08}) begin
            errors++;
            $display("FAIL mem_read_req%0d got %h want %h", i,
                     {oMemRead, oMemWrite, oStep}, 10'h208);
         end
         if (i == 3) begin
            iMemAck  = 1'b1;
            iMemData = 32'hDEAD_BEEF;
         end
         tick();
      end
      iMemAck  = 1'b0;
      iMemData = 32'h0;
      checks++;
      if ({oMDR, oStep, oMemRead} !== {32'hDEAD_BEEF, 8'h10, 1'b0}) begin
         errors++;
         $display("FAIL mem_read_mdr got %h want %h", {oMDR, oStep, oMemRead},
                  {32'hDEAD_BEEF, 8'h10, 1'b0});
      end
      checks++;
      if (oIR !== 32'hA000_0001) begin
         errors++;
         $display("FAIL mem_read_ir got %h want %h", oIR, 32'hA000_0001);
      end
      tick();
      checks++;
      if ({oFetch, oStep} !== {1'b1, 8'h01}) begin
         errors++;
         $display("FAIL mem_read_refetch got %h want %h", {oFetch, oStep}, 9'h101);
      end
   endtask

   task automatic test_stall_clamp();
      set_defaults();
      do_reset();
      iRdy = 1'b1;
      tick();
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      tick();
      iRdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({oStep, oMemRead, oMemWrite} !== {8'h04, 2'b00}) begin
            errors++;
            $display("FAIL stall%0d got %h want %h", i, {oStep, oMemRead, oMemWrite}, 10'h010);
         end
      end
      iRdy = 1'b1;
      tick();
      checks++;
      if (oStep !== 8'h08) begin
         errors++;
         $display("FAIL stall_resume got %h want %h", oStep, 8'h08);
      end
      // iLen=1 behaves as 2: fetch then one exec step.
      iLen = 4'd1;
      tick();
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      checks++;
      if (oStep !== 8'h02) begin
         errors++;
         $display("FAIL clamp_lo_step got %h want %h", oStep, 8'h02);
      end
      tick();
      checks++;
      if ({oFetch, oStep} !== {1'b1, 8'h01}) begin
         errors++;
         $display("FAIL clamp_lo_fetch got %h want %h", {oFetch, oStep}, 9'h101);
      end
      // iLen=12 behaves as 8: steps 1..7, then fetch.
      iLen    = 4'd12;
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      for (int i = 1; i < 8; i++) begin
         checks++;
         if ({oFetch, oStep} !== {1'b0, 8'(1 << i)}) begin
            errors++;
            $display("FAIL clamp_hi_step%0d got %h want %h", i, {oFetch, oStep},
                     {1'b0, 8'(1 << i)});
         end
         tick();
      end
      checks++;
      if ({oFetch, oStep} !== {1'b1, 8'h01}) begin
         errors++;
         $display("FAIL clamp_hi_fetch got %h want %h", {oFetch, oStep}, 9'h101);
      end
   endtask

   task automatic test_halt();
      set_defaults();
      do_reset();
      iRdy  = 1'b1;
      iHalt = 1'b1;
      tick();
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({oHalted, oStep, oMemRead, oMemWrite, oFetch} !== {1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL halt%0d got %h want %h", i,
                     {oHalted, oStep, oMemRead, oMemWrite, oFetch}, 12'h800);
         end
         tick();
      end
      iHalt = 1'b0;
      iRun  = 1'b1;
      tick();
      iRun = 1'b0;
      checks++;
      if ({oFetch, oHalted, oStep} !== {1'b1, 1'b0, 8'h01}) begin
         errors++;
         $display("FAIL halt_resume got %h want %h", {oFetch, oHalted, oStep}, 10'h201);
      end
   endtask

   task automatic test_timeout();
      set_defaults();
      do_reset();
      iRdy = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) begin
         checks++;
         if ({oErr, oMemRead} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_wait%0d got %b want %b", i, {oErr, oMemRead}, 2'b01);
         end
         tick();
      end
      checks++;
      if ({oErr, oMemRead, oFetch} !== 3'b100) begin
         errors++;
         $display("FAIL timeout_err got %b want %b", {oErr, oMemRead, oFetch}, 3'b100);
      end
      iMemAck = 1'b1;
      iRun    = 1'b1;
      tick();
      tick();
      iMemAck = 1'b0;
      iRun    = 1'b0;
      checks++;
      if ({oErr, oMemRead, oStep} !== {1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL timeout_sticky got %h want %h", {oErr, oMemRead, oStep}, 10'h200);
      end
   endtask

   task automatic test_timeout_ack();
      set_defaults();
      do_reset();
      iRdy = 1'b1;
      tick();
      for (int i = 0; i < 14; i++) tick();
      iMemAck  = 1'b1;
      iMemData = 32'h0BAD_F00D;
      tick();
      iMemAck = 1'b0;
      checks++;
      if ({oErr, oStep, oIR} !== {1'b0, 8'h02, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL timeout_ack got %h want %h", {oErr, oStep, oIR},
                  {1'b0, 8'h02, 32'h0BAD_F00D});
      end
   endtask

   task automatic test_reset_mid_write();
      set_defaults();
      do_reset();
      iRdy     = 1'b1;
      iMemEn   = 1'b1;
      iMemStep = 3'd2;
      iMemWr   = 1'b1;
      tick();
      iMemAck  = 1'b1;
      iMemData = 32'hCAFE_F00D;
      tick();
      iMemAck = 1'b0;
      tick();
      checks++;
      if ({oMemWrite, oMemRead, oStep, oIR} !== {2'b10, 8'h04, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL write_req got %h want %h", {oMemWrite, oMemRead, oStep, oIR},
                  {2'b10, 8'h04, 32'hCAFE_F00D});
      end
      nRst = 1'b0;
      #1;
      checks++;
      if ({oMemWrite, oMemRead, oStep, oFetch, oIR} !== 43'h0) begin
         errors++;
         $display("FAIL write_reset got %h want %h", {oMemWrite, oMemRead, oStep, oFetch, oIR},
                  43'h0);
      end
      nRst = 1'b1;
      tick();
   endtask

`ifdef CTRL_SEQ_SSTEP_EN
   task automatic test_step_mode();
      set_defaults();
      iStepMode = 1'b1;
      do_reset();
      iRdy = 1'b1;
      tick();
      checks++;
      if (oFetch !== 1'b0) begin
         errors++;
         $display("FAIL sstep_wait got %b want 0", oFetch);
      end
      iStepGo = 1'b1;
      tick();
      iStepGo = 1'b0;
      checks++;
      if (oFetch !== 1'b1) begin
         errors++;
         $display("FAIL sstep_go got %b want 1", oFetch);
      end
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      tick();
      tick();
      tick();
      tick();
      checks++;
      if ({oFetch, oStep} !== 9'h000) begin
         errors++;
         $display("FAIL sstep_park got %h want %h", {oFetch, oStep}, 9'h000);
      end
      checks++;
      if (oFetch !== 1'b0) begin
         errors++;
         $display("FAIL sstep_hold got %b want 0", oFetch);
      end
      iStepGo = 1'b1;
      tick();
      iStepGo = 1'b0;
      checks++;
      if ({oFetch, oStep} !== 9'h101) begin
         errors++;
         $display("FAIL sstep_next got %h want %h", {oFetch, oStep}, 9'h101);
      end
   endtask
`endif

   initial begin
      set_defaults();
      nRst = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_mem_read();
      test_stall_clamp();
      test_halt();
      test_timeout();
      test_timeout_ack();
      test_reset_mid_write();
`ifdef CTRL_SEQ_SSTEP_EN
      test_step_mode();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
